lp_escape_rx_ctrl: RTL
======================

# lp_escape_rx_ctrl

Low-Power Escape Mode receive controller for the C-PHY slave lane. It filters the LP line levels on A/B/C and walks the Escape Mode entry sequence. It enables the LP clock-recovery XOR (A^C) only while Escape Mode is active, and decodes the spaced-one-hot bit stream into an entry command followed by LPDT bytes, ULPS, or trigger events. It sits between the LP receivers and the lane's PPI-side Escape interface, all in the `clk` domain.

## Interface
- `FILT_CYC`, 2: cycles a new LP line state must be stable before it is accepted (range 1..15)
- `clk` in 1: controller clock (≥4x the maximum escape bit rate)
- `rst` in 1: synchronous, active-high reset
- `lp_a`, `lp_b`, `lp_c` in 1 each: LP receiver outputs, already synchronized to `clk`
- `clk_rec_en` out 1: enables the LP clock-recovery path; high only in CMD/LPDT/TRIG states
- `esc_active` out 1: high from end of entry sequence until Stop is seen
- `lpdt_active` out 1: high in LPDT state
- `ulps_active` out 1: high in ULPS state
- `rx_data` out 8: last received LPDT byte
- `rx_valid` out 1: one-cycle strobe, `rx_data` valid
- `trig_valid` out 1: one-cycle strobe, trigger received
- `trig_code` out 2: 0 Reset, 1 Unknown-3, 2 Unknown-4, 3 Unknown-5
- `err_esc` out 1: one-cycle strobe, unrecognised entry command
- `err_sync` out 1: one-cycle strobe, illegal line state, or Stop arrived mid-byte

## Operation
- Line state is S = {A,B,C}. Filtered state F updates to S after S has been stable for FILT_CYC consecutive cycles.
- States: STOP, E1, E2, E3, CMD, LPDT, ULPS, TRIG, ERRW.
- Entry sequence: STOP (F=111) → E1 on F=100 → E2 on F=000 → E3 on F=001 → CMD on F=000. Any other F during E1–E3 returns to STOP without error.
- Bits (CMD/LPDT/TRIG): a mark is an F change 000→100 (bit 1) or 000→001 (bit 0). The space 000 must be seen between marks.
- In CMD/LPDT/TRIG, F ∈ {010,011,101,110} → pulse `err_sync`, go to ERRW.
- CMD: shift 8 bits MSB-first, then compare:
  - 0x1E → ULPS
  - 0xE1 → LPDT
  - 0x62 / 0x5D / 0x21 / 0xA0 → pulse `trig_valid` with code 0/1/2/3, go to TRIG
  - other → pulse `err_esc`, go to ERRW
- LPDT: bytes shifted LSB-first. On the 8th bit: update `rx_data`, pulse `rx_valid`, reset the 3-bit counter, and stay in LPDT.
- TRIG and ULPS ignore marks.
- F=111 from any state except STOP → STOP. Bits already received are discarded.
  - If this happens in CMD or LPDT with bit count ≠ 0, pulse `err_sync` in the same cycle.
- ERRW waits for F=111.
- Reset values:
  - state STOP, F=111
  - all outputs 0, including `rx_data`=0x00 and `trig_code`=0
  - bit counter 0, filter counter 0

## Timing
- Filter latency: F changes FILT_CYC cycles after the raw input changes (FILT_CYC=2: change at edge n, F at edge n+2).
- Strobes (`rx_valid`, `trig_valid`, `err_*`) assert the cycle after F shows the completing mark, for exactly one cycle.
- `clk_rec_en` and `esc_active` assert the cycle after F=000 completes entry, and deassert the cycle after F=111.
- `rst` during any state: all registers return to reset values at the next edge. Any partial byte is lost and no strobe is issued.

## Configuration
- `LP_TRIGGER_EN`
  - Defined: trigger codes are decoded as above.
  - Undefined: the four trigger codes are treated as unrecognised (`err_esc`, ERRW), `trig_valid`/`trig_code` are tied to 0, and the TRIG state is removed.

## Structure
- Shared package `cphy_lp_pkg`: state enum, line-state constants (LP_111, LP_100, LP_000, LP_001), and command constants (ULPS 0x1E, LPDT 0xE1, the four trigger codes).
- One sub-module, `lp_glitch_filter`: FILT_CYC stability filter on the 3-bit line state, reset value 111.

## Test plan
- Entry 111→100→000→001→000, then marks for 0xE1, then 0xA5 LSB-first → `lpdt_active`=1, one `rx_valid` with `rx_data`=0xA5.
- Entry, then 0x1E, then 111 → `ulps_active`=1 until Stop, then all outputs 0 and no errors.
- Entry, then 0x62 → `trig_valid` one cycle with `trig_code`=0. Repeat without `LP_TRIGGER_EN` → `err_esc` pulse, no `trig_valid`.
- In LPDT after 3 bits of a byte, drive 111 → `err_sync` pulse, return to STOP, no `rx_valid`.
- Glitch of FILT_CYC-1 cycles to 100 while in STOP → no state change. Drive 110 in LPDT → `err_sync` pulse, then ERRW until 111.
- Assert `rst` mid-byte in LPDT → next cycle all outputs at reset values and state STOP.

Source files
------------

// File: rtl/cphy_lp_pkg.sv
// Shared definitions for the C-PHY LP escape receive path: FSM states, line levels, entry commands.
// Optional feature macro: LP_TRIGGER_EN (trigger command decode and the TRIG state).
package cphy_lp_pkg;

  typedef enum logic [3:0] {
    ST_STOP = 4'd0,
    ST_E1   = 4'd1,
    ST_E2   = 4'd2,
    ST_E3   = 4'd3,
    ST_CMD  = 4'd4,
    ST_LPDT = 4'd5,
    ST_ULPS = 4'd6,
`ifdef LP_TRIGGER_EN
    ST_TRIG = 4'd7,
`endif
    ST_ERRW = 4'd8
  } lp_state_e;

  // Line state is packed as {A,B,C}.
  localparam logic [2:0] LP_111 = 3'b111;
  localparam logic [2:0] LP_100 = 3'b100;
  localparam logic [2:0] LP_000 = 3'b000;
  localparam logic [2:0] LP_001 = 3'b001;

  localparam logic [7:0] CMD_ULPS       = 8'h1E;
  localparam logic [7:0] CMD_LPDT       = 8'hE1;
  localparam logic [7:0] CMD_TRIG_RESET = 8'h62;
  localparam logic [7:0] CMD_TRIG_UNK3  = 8'h5D;
  localparam logic [7:0] CMD_TRIG_UNK4  = 8'h21;
  localparam logic [7:0] CMD_TRIG_UNK5  = 8'hA0;

  function automatic logic is_illegal(input logic [2:0] f);
    return (f == 3'b010) || (f == 3'b011) || (f == 3'b101) || (f == 3'b110);
  endfunction

`ifdef LP_TRIGGER_EN
  // Returns {hit, code}.
  function automatic logic [2:0] trig_lookup(input logic [7:0] cmd);
    case (cmd)
      CMD_TRIG_RESET: return 3'b100;
      CMD_TRIG_UNK3:  return 3'b101;
      CMD_TRIG_UNK4:  return 3'b110;
      CMD_TRIG_UNK5:  return 3'b111;
      default:        return 3'b000;
    endcase
  endfunction
`endif

endpackage

// File: rtl/lp_glitch_filter.sv
// Stability filter on the 3-bit LP line state: output follows the input only after
// it has held a new value for FILT_CYC consecutive cycles. Resets to 111 (Stop).
module lp_glitch_filter
  import cphy_lp_pkg::*;
#(
  parameter int FILT_CYC = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] line,
  output logic [2:0] filt
);

  logic [2:0] cand;
  logic [3:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      filt <= LP_111;
      cand <= LP_111;
      cnt  <= '0;
    end else if (line == filt) begin
      cnt <= '0;
    end else if (cnt == 4'd0 || line != cand) begin
      // First cycle of a new candidate value.
      cand <= line;
      if (FILT_CYC == 1) begin
        filt <= line;
        cnt  <= '0;
      end else begin
        cnt <= 4'd1;
      end
    end else if (cnt == 4'(FILT_CYC - 1)) begin
      filt <= line;
      cnt  <= '0;
    end else begin
      cnt <= cnt + 4'd1;
    end
  end

endmodule

// File: rtl/lp_escape_rx_ctrl.sv
// C-PHY slave-lane LP Escape Mode receiver: filters A/B/C, walks the entry sequence and
// decodes spaced-one-hot marks into command, LPDT bytes, ULPS or triggers (LP_TRIGGER_EN).
module lp_escape_rx_ctrl
  import cphy_lp_pkg::*;
#(
  parameter int FILT_CYC = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       lp_a,
  input  logic       lp_b,
  input  logic       lp_c,
  output logic       clk_rec_en,
  output logic       esc_active,
  output logic       lpdt_active,
  output logic       ulps_active,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       trig_valid,
  output logic [1:0] trig_code,
  output logic       err_esc,
  output logic       err_sync,
  output logic [3:0] state_dbg
);

  lp_state_e  state, state_n;
  logic [2:0] f, f_prev;
  logic [7:0] shreg, sh_n;
  logic [2:0] bit_cnt, cnt_n;
  logic [7:0] rx_data_n;
  logic       rx_valid_n, err_esc_n, err_sync_n;
  logic       mark, bit_val;
  logic [7:0] byte_msb, byte_lsb;

  lp_glitch_filter #(.FILT_CYC(FILT_CYC)) u_filt (
    .clk  (clk),
    .rst  (rst),
    .line ({lp_a, lp_b, lp_c}),
    .filt (f)
  );

  // A mark is a transition out of the 000 space; 100 carries a 1, 001 a 0.
  assign mark     = (f != f_prev) && (f_prev == LP_000) && ((f == LP_100) || (f == LP_001));
  assign bit_val  = (f == LP_100);
  assign byte_msb = {shreg[6:0], bit_val};
  assign byte_lsb = {bit_val, shreg[7:1]};

`ifdef LP_TRIGGER_EN
  logic       trig_valid_q, trig_valid_n;
  logic [1:0] trig_code_q, trig_code_n;
  logic [2:0] tl;
  assign tl         = trig_lookup(byte_msb);
  assign trig_valid = trig_valid_q;
  assign trig_code  = trig_code_q;
  assign clk_rec_en = (state == ST_CMD) || (state == ST_LPDT) || (state == ST_TRIG);
`else
  assign trig_valid = 1'b0;
  assign trig_code  = 2'b00;
  assign clk_rec_en = (state == ST_CMD) || (state == ST_LPDT);
`endif

  assign esc_active  = (state != ST_STOP) && (state != ST_E1) && (state != ST_E2) && (state != ST_E3);
  assign lpdt_active = (state == ST_LPDT);
  assign ulps_active = (state == ST_ULPS);
  assign state_dbg   = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_STOP;
      f_prev   <= LP_111;
      shreg    <= '0;
      bit_cnt  <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      err_esc  <= 1'b0;
      err_sync <= 1'b0;
`ifdef LP_TRIGGER_EN
      trig_valid_q <= 1'b0;
      trig_code_q  <= 2'b00;
`endif
    end else begin
      state    <= state_n;
      f_prev   <= f;
      shreg    <= sh_n;
      bit_cnt  <= cnt_n;
      rx_data  <= rx_data_n;
      rx_valid <= rx_valid_n;
      err_esc  <= err_esc_n;
      err_sync <= err_sync_n;
`ifdef LP_TRIGGER_EN
      trig_valid_q <= trig_valid_n;
      trig_code_q  <= trig_code_n;
`endif
    end
  end

  always_comb begin
    state_n    = state;
    sh_n       = shreg;
    cnt_n      = bit_cnt;
    rx_data_n  = rx_data;
    rx_valid_n = 1'b0;
    err_esc_n  = 1'b0;
    err_sync_n = 1'b0;
`ifdef LP_TRIGGER_EN
    trig_valid_n = 1'b0;
    trig_code_n  = trig_code_q;
`endif
    case (state)
      ST_STOP: begin
        cnt_n = '0;
        if (f == LP_100) state_n = ST_E1;
      end
      ST_E1: begin
        if (f == LP_000) state_n = ST_E2;
        else if (f != LP_100) state_n = ST_STOP;
      end
      ST_E2: begin
        if (f == LP_001) state_n = ST_E3;
        else if (f != LP_000) state_n = ST_STOP;
      end
      ST_E3: begin
        if (f == LP_000) begin
          state_n = ST_CMD;
          cnt_n   = '0;
        end else if (f != LP_001) begin
          state_n = ST_STOP;
        end
      end
      ST_CMD: begin
        if (is_illegal(f)) begin
          err_sync_n = 1'b1;
          state_n    = ST_ERRW;
        end else if (mark) begin
          sh_n  = byte_msb;
          cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            if (byte_msb == CMD_ULPS) begin
              state_n = ST_ULPS;
            end else if (byte_msb == CMD_LPDT) begin
              state_n = ST_LPDT;
`ifdef LP_TRIGGER_EN
            end else if (tl[2]) begin
              trig_valid_n = 1'b1;
              trig_code_n  = tl[1:0];
              state_n      = ST_TRIG;
`endif
            end else begin
              err_esc_n = 1'b1;
              state_n   = ST_ERRW;
            end
          end
        end
      end
      ST_LPDT: begin
        if (is_illegal(f)) begin
          err_sync_n = 1'b1;
          state_n    = ST_ERRW;
        end else if (mark) begin
          sh_n  = byte_lsb;
          cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            rx_data_n  = byte_lsb;
            rx_valid_n = 1'b1;
          end
        end
      end
`ifdef LP_TRIGGER_EN
      ST_TRIG: begin
        if (is_illegal(f)) begin
          err_sync_n = 1'b1;
          state_n    = ST_ERRW;
        end
      end
`endif
      default: ;
    endcase
    // Stop aborts everything; a partially shifted byte is flagged as a sync error.
    if (state != ST_STOP && f == LP_111) begin
      state_n    = ST_STOP;
      cnt_n      = '0;
      err_sync_n = ((state == ST_CMD) || (state == ST_LPDT)) && (bit_cnt != 3'd0);
    end
  end

endmodule
